seg_scan_capture: RTL and testbench
===================================

SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, meaning consecutive stable input samples required before a digit is captured (legal range 1..255).
REQ-002 Parameter NUM_DIGITS, default 4, meaning number of multiplexed digit positions scanned.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 an  input  NUM_DIGITS  active-low digit-select lines; an[i] low selects position i.
REQ-006 seven_seg  input  7  active-low segment pattern, bit6 = segment a through bit0 = segment g.
REQ-007 value  output  4*NUM_DIGITS  last good frame; position i occupies bits [4i+3:4i].
REQ-008 value_valid  output  1  one-cycle pulse when value is updated.
REQ-009 frame_err  output  1  one-cycle pulse when a completed frame held an unrecognized pattern.
REQ-010 blank_mask  output  NUM_DIGITS  bit i set when position i was blank in the last good frame.

Function
REQ-011 an and seven_seg SHALL be registered once on entry; all decisions use the registered copies.
REQ-012 Decode table (pattern -> code): 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 0001000->A, 1100000->B, 0110001->C; 1111111->blank (code F); every other pattern is invalid.
REQ-013 FSM states: IDLE, SETTLE, HELD.
REQ-014 IDLE: registered an not exactly one bit low; settle counter held at 0; no capture.
REQ-015 IDLE->SETTLE when registered an is exactly one bit low; counter loads 1.
REQ-016 SETTLE: counter increments each cycle registered an and seven_seg equal the previous cycle's values; any change restarts at count 1 (or goes to IDLE if an is no longer one-hot).
REQ-017 SETTLE->HELD in the cycle the counter reaches SETTLE_CYCLES; that cycle captures the decoded code into slot i, sets captured-mask bit i, and records blank/invalid for slot i.
REQ-018 HELD: no further capture; any change in an or seven_seg returns to SETTLE (count 1) or IDLE per REQ-014.
REQ-019 Re-capture of an already-captured slot before frame completion SHALL overwrite code and flags.
REQ-020 In the cycle after the capture that completes the captured mask: if no slot is invalid, value and blank_mask update and value_valid pulses; otherwise value/blank_mask hold and frame_err pulses; mask and flags clear in that cycle.
REQ-021 value_valid and frame_err SHALL never be high together; captures proceeding in the completion cycle SHALL count toward the next frame.
REQ-022 Latency: pattern stable at inputs from cycle t gives capture at cycle t+SETTLE_CYCLES; value_valid at t+SETTLE_CYCLES+1 when that capture completes the frame.

Reset
REQ-023 rst SHALL force FSM to IDLE, counter, captured mask, slot codes/flags, value, blank_mask, value_valid, frame_err and the input registers (an to all-ones, seven_seg to 1111111) to their idle values; value and blank_mask reset to 0.
REQ-024 rst asserted mid-frame SHALL discard all partial captures; no pulse is produced for the discarded frame.

Configuration
REQ-025 Macro SEG_SCAN_ERR_CNT_EN: when defined, an extra output err_count (8 bits) counts frame_err pulses, saturating at 255, cleared by rst; when undefined, the port and counter are absent and behaviour is otherwise identical.

Structure
REQ-026 Shared package holds the FSM state enumeration, the 13 digit-pattern constants, the blank pattern constant and the blank code constant.
REQ-027 Sub-module seg_pattern_decode (combinational: 7-bit pattern -> 4-bit code, blank flag, invalid flag) instantiated once.

Verification
REQ-028 Scan an 1110,1101,1011,0111 with patterns for 1,2,3,4, each held 6 cycles -> value_valid one pulse, value = 16'h4321, blank_mask = 0000.
REQ-029 Same scan with position 2 at 1111111 -> value = 16'h4F21, blank_mask = 0100, value_valid pulse.
REQ-030 Position 1 pattern 1111110 -> frame_err pulse, value unchanged, value_valid low; err_count = 1 with SEG_SCAN_ERR_CNT_EN.
REQ-031 Pattern toggles every 2 cycles with SETTLE_CYCLES=4, and an = 1100 held -> no capture, no pulses.
REQ-032 rst after three of four captures, then one full scan of 9,8,7,6 -> exactly one value_valid, value = 16'h6789.
REQ-033 Single stable position held 100 cycles -> exactly one capture; value_valid only after remaining positions are scanned.

Source files
------------

// File: rtl/seg_scan_capture_pkg.sv
// seg_scan_capture_pkg: shared FSM state type and seven-segment pattern constants.
// Patterns are active-low, bit6 = segment a ... bit0 = segment g.
package seg_scan_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } state_t;

  localparam logic [6:0] PAT_0 = 7'b0000001;
  localparam logic [6:0] PAT_1 = 7'b1001111;
  localparam logic [6:0] PAT_2 = 7'b0010010;
  localparam logic [6:0] PAT_3 = 7'b0000110;
  localparam logic [6:0] PAT_4 = 7'b1001100;
  localparam logic [6:0] PAT_5 = 7'b0100100;
  localparam logic [6:0] PAT_6 = 7'b0100000;
  localparam logic [6:0] PAT_7 = 7'b0001111;
  localparam logic [6:0] PAT_8 = 7'b0000000;
  localparam logic [6:0] PAT_9 = 7'b0000100;
  localparam logic [6:0] PAT_A = 7'b0001000;
  localparam logic [6:0] PAT_B = 7'b1100000;
  localparam logic [6:0] PAT_C = 7'b0110001;

  localparam logic [6:0] PAT_BLANK  = 7'b1111111;
  localparam logic [3:0] CODE_BLANK = 4'hF;

endpackage

// File: rtl/seg_scan_capture_if.sv
// seg_scan_capture_if: scanned display lines in (an, seven_seg), decoded frame out.
// master = display/scanner side, slave = capture side. err_count under SEG_SCAN_ERR_CNT_EN.
interface seg_scan_capture_if #(
  parameter int NUM_DIGITS = 4
);

  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seven_seg;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    value_valid;
  logic                    frame_err;
  logic [NUM_DIGITS-1:0]   blank_mask;
`ifdef SEG_SCAN_ERR_CNT_EN
  logic [7:0]              err_count;
`endif

  modport master (
    output an, seven_seg,
    input  value, value_valid, frame_err, blank_mask
`ifdef SEG_SCAN_ERR_CNT_EN
    , input err_count
`endif
  );

  modport slave (
    input  an, seven_seg,
    output value, value_valid, frame_err, blank_mask
`ifdef SEG_SCAN_ERR_CNT_EN
    , output err_count
`endif
  );

endinterface

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: combinational 7-bit segment pattern -> hex code, blank, invalid.
// Ports: pattern (in), code / blank / invalid (out); invalid patterns report code F.
module seg_pattern_decode
  import seg_scan_capture_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       blank,
  output logic       invalid
);

  always_comb begin
    code    = CODE_BLANK;
    blank   = 1'b0;
    invalid = 1'b0;
    unique case (1'b1)
      pattern == PAT_0:     code = 4'h0;
      pattern == PAT_1:     code = 4'h1;
      pattern == PAT_2:     code = 4'h2;
      pattern == PAT_3:     code = 4'h3;
      pattern == PAT_4:     code = 4'h4;
      pattern == PAT_5:     code = 4'h5;
      pattern == PAT_6:     code = 4'h6;
      pattern == PAT_7:     code = 4'h7;
      pattern == PAT_8:     code = 4'h8;
      pattern == PAT_9:     code = 4'h9;
      pattern == PAT_A:     code = 4'hA;
      pattern == PAT_B:     code = 4'hB;
      pattern == PAT_C:     code = 4'hC;
      pattern == PAT_BLANK: blank = 1'b1;
      default:              invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: debounce a multiplexed 7-seg scan and assemble whole frames.
// Ports: clk, rst (sync, high), bus (slave). Optional err_count: SEG_SCAN_ERR_CNT_EN.
module seg_scan_capture
  import seg_scan_capture_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 4
) (
  input logic               clk,
  input logic               rst,
  seg_scan_capture_if.slave bus
);

  localparam int                    W        = 4 * NUM_DIGITS;
  localparam logic [7:0]            SETTLE_N = 8'(SETTLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] ALL      = '1;

  logic [NUM_DIGITS-1:0] an_r, an_p, sel;
  logic [6:0]            seg_r, seg_p;
  logic [NUM_DIGITS-1:0] mask_q, mask_n;
  logic [NUM_DIGITS-1:0] blank_q, blank_n;
  logic [NUM_DIGITS-1:0] inval_q, inval_n;
  logic [W-1:0]          code_q, code_n;
  logic [W-1:0]          value_q;
  logic [NUM_DIGITS-1:0] bmask_q;
  logic                  vv_q, fe_q;
  logic [7:0]            cnt_q, cnt_n;
  state_t                state_q, state_n;
  logic                  one_low, stable, hold, capture, done;
  logic [3:0]            dec_code;
  logic                  dec_blank, dec_inval;

  seg_pattern_decode u_dec (
    .pattern (seg_r),
    .code    (dec_code),
    .blank   (dec_blank),
    .invalid (dec_inval)
  );

  assign sel     = ~an_r;
  assign one_low = $onehot(sel);
  assign stable  = (an_r == an_p) && (seg_r == seg_p);
  assign hold    = (state_q == HELD) && stable;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    capture = 1'b0;
    if (!one_low) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (!hold) begin
      if (state_q == SETTLE && stable)
        cnt_n = cnt_q + 8'd1;
      else
        cnt_n = 8'd1;
      capture = (cnt_n == SETTLE_N);
      state_n = capture ? HELD : SETTLE;
    end
  end

  always_comb begin
    code_n  = code_q;
    blank_n = blank_q;
    inval_n = inval_q;
    mask_n  = mask_q;
    if (capture) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (sel[i]) code_n[4*i +: 4] = dec_code;
      blank_n = dec_blank ? (blank_q | sel) : (blank_q & ~sel);
      inval_n = dec_inval ? (inval_q | sel) : (inval_q & ~sel);
      mask_n  = mask_q | sel;
    end
  end

  // Completion is resolved on the capturing edge, so the pulse
  // appears in the cycle right after the completing capture.
  assign done = (mask_n == ALL);

  always_ff @(posedge clk) begin
    if (rst) begin
      an_r    <= '1;
      seg_r   <= PAT_BLANK;
      an_p    <= '1;
      seg_p   <= PAT_BLANK;
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      blank_q <= '0;
      inval_q <= '0;
      code_q  <= '0;
      value_q <= '0;
      bmask_q <= '0;
      vv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      an_r    <= bus.an;
      seg_r   <= bus.seven_seg;
      an_p    <= an_r;
      seg_p   <= seg_r;
      state_q <= state_n;
      cnt_q   <= cnt_n;
      code_q  <= code_n;
      vv_q    <= 1'b0;
      fe_q    <= 1'b0;
      if (done) begin
        mask_q  <= '0;
        blank_q <= '0;
        inval_q <= '0;
        if (inval_n == '0) begin
          value_q <= code_n;
          bmask_q <= blank_n;
          vv_q    <= 1'b1;
        end else begin
          fe_q <= 1'b1;
        end
      end else begin
        mask_q  <= mask_n;
        blank_q <= blank_n;
        inval_q <= inval_n;
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.blank_mask  = bmask_q;
  assign bus.value_valid = vv_q;
  assign bus.frame_err   = fe_q;

`ifdef SEG_SCAN_ERR_CNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= '0;
    else if (fe_q && err_q != 8'hFF)
      err_q <= err_q + 8'd1;
  end

  assign bus.err_count = err_q;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed scans checked every cycle against a frame-level model.
// Literal checks pin the model for the main scenarios.
module tb_seg_scan_capture;

  localparam int N  = 4;
  localparam int ST = 4;

  localparam logic [6:0] PATS [13] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001
  };
  localparam logic [6:0] BLK = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] drv_an = 4'hF;
  logic [6:0] drv_seg = BLK;

  int n_tests = 0;
  int n_fail  = 0;
  int vv_cnt  = 0;
  int fe_cnt  = 0;

  always #5 clk = ~clk;

  seg_scan_capture_if #(.NUM_DIGITS(N)) bus ();

  assign bus.an        = drv_an;
  assign bus.seven_seg = drv_seg;

  seg_scan_capture #(
    .SETTLE_CYCLES (ST),
    .NUM_DIGITS    (N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model: a digit is captured once a one-hot-low (an, seg) pair has
  // been sampled ST times in a row; a full set of captures forms a frame.
  int         slot_code [N];
  bit         slot_cap [N];
  bit         slot_blk [N];
  bit         slot_inv [N];
  logic [3:0] prev_an;
  logic [6:0] prev_seg;
  int         run;
  bit         started = 0;
  bit         e_vv, e_fe, p_vv, p_fe;
  logic [15:0] e_value, p_value;
  logic [3:0]  e_blank, p_blank;
  int          e_err;

  function automatic void decode(input logic [6:0] s, output int code,
                                 output bit blk, output bit inv);
    blk  = (s == BLK);
    inv  = !blk;
    code = 15;
    for (int k = 0; k < 13; k++)
      if (PATS[k] == s) begin
        code = k;
        inv  = 0;
      end
  endfunction

  task automatic clear_slots();
    for (int i = 0; i < N; i++) begin
      slot_cap[i] = 0;
      slot_blk[i] = 0;
      slot_inv[i] = 0;
    end
  endtask

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      clear_slots();
      run = 0;
      prev_an = 4'hF;
      prev_seg = BLK;
      e_vv = 0; e_fe = 0; p_vv = 0; p_fe = 0;
      e_value = 0; e_blank = 0; e_err = 0;
    end else begin
      e_vv = p_vv;
      e_fe = p_fe;
      if (p_vv) begin
        e_value = p_value;
        e_blank = p_blank;
      end
      if (p_fe && e_err < 255) e_err++;
      p_vv = 0;
      p_fe = 0;
      if ($countones(~drv_an) == 1)
        run = (drv_an == prev_an && drv_seg == prev_seg) ? run + 1 : 1;
      else
        run = 0;
      prev_an = drv_an;
      prev_seg = drv_seg;
      if (run == ST) begin
        int idx, c;
        bit b, v, all, bad;
        idx = 0;
        for (int i = 0; i < N; i++) if (!drv_an[i]) idx = i;
        decode(drv_seg, c, b, v);
        slot_code[idx] = c;
        slot_blk[idx] = b;
        slot_inv[idx] = v;
        slot_cap[idx] = 1;
        all = 1;
        bad = 0;
        for (int i = 0; i < N; i++) begin
          all &= slot_cap[i];
          bad |= slot_inv[i];
        end
        if (all) begin
          if (bad) p_fe = 1;
          else begin
            p_vv = 1;
            for (int i = 0; i < N; i++) begin
              p_value[4*i +: 4] = 4'(slot_code[i]);
              p_blank[i] = slot_blk[i];
            end
          end
          clear_slots();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      if (bus.value_valid) vv_cnt++;
      if (bus.frame_err) fe_cnt++;
      n_tests++;
      if (bus.value_valid !== e_vv || bus.frame_err !== e_fe ||
          bus.value !== e_value || bus.blank_mask !== e_blank) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t got vv=%b fe=%b val=%h blk=%b exp vv=%b fe=%b val=%h blk=%b",
                 $time, bus.value_valid, bus.frame_err, bus.value, bus.blank_mask,
                 e_vv, e_fe, e_value, e_blank);
      end
      n_tests++;
      if (bus.value_valid && bus.frame_err) begin
        n_fail++;
        $display("FAIL both_pulses t=%0t got 1/1 exp not both", $time);
      end
`ifdef SEG_SCAN_ERR_CNT_EN
      n_tests++;
      if (int'(bus.err_count) != e_err) begin
        n_fail++;
        $display("FAIL err_count_cmp got %0d exp %0d", bus.err_count, e_err);
      end
`endif
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    drv_an = a;
    drv_seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                      input logic [6:0] p2, input logic [6:0] p3, input int n);
    hold(4'b1110, p0, n);
    hold(4'b1101, p1, n);
    hold(4'b1011, p2, n);
    hold(4'b0111, p3, n);
    hold(4'b1111, BLK, 3);
  endtask

  int v0, f0;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_value", int'(bus.value), 0);
    check("reset_blank", int'(bus.blank_mask), 0);
    check("reset_vv", int'(bus.value_valid), 0);

    v0 = vv_cnt;
    scan(PATS[1], PATS[2], PATS[3], PATS[4], 6);
    check("scan_4321_vv", vv_cnt - v0, 1);
    check("scan_4321_val", int'(bus.value), 'h4321);
    check("scan_4321_blk", int'(bus.blank_mask), 0);

    v0 = vv_cnt;
    scan(PATS[1], PATS[2], BLK, PATS[4], 6);
    check("blank_vv", vv_cnt - v0, 1);
    check("blank_val", int'(bus.value), 'h4F21);
    check("blank_blk", int'(bus.blank_mask), 'b0100);

    v0 = vv_cnt; f0 = fe_cnt;
    scan(PATS[1], 7'b1111110, PATS[3], PATS[4], 6);
    check("err_fe", fe_cnt - f0, 1);
    check("err_vv", vv_cnt - v0, 0);
    check("err_val", int'(bus.value), 'h4F21);
`ifdef SEG_SCAN_ERR_CNT_EN
    check("err_count", int'(bus.err_count), 1);
`endif

    v0 = vv_cnt; f0 = fe_cnt;
    for (int k = 0; k < 8; k++) hold(4'b1100, PATS[k % 2 + 1], 2);
    for (int k = 0; k < 6; k++) hold(4'b1110, PATS[k % 2 + 1], 2);
    hold(4'b1111, BLK, 3);
    check("toggle_vv", vv_cnt - v0, 0);
    check("toggle_fe", fe_cnt - f0, 0);

    v0 = vv_cnt;
    hold(4'b1110, PATS[7], 6);
    hold(4'b1110, PATS[8], 6);
    scan(PATS[8], PATS[1], PATS[2], PATS[3], 6);
    check("overwrite_vv", vv_cnt - v0, 1);
    check("overwrite_val", int'(bus.value), 'h3218);

    v0 = vv_cnt;
    hold(4'b1110, PATS[5], 3);
    hold(4'b1111, BLK, 2);
    scan(PATS[0], PATS[9], PATS[8], PATS[12], ST);
    check("edge_vv", vv_cnt - v0, 1);
    check("edge_val", int'(bus.value), 'hC890);

    v0 = vv_cnt; f0 = fe_cnt;
    hold(4'b1110, PATS[9], 6);
    hold(4'b1101, PATS[8], 6);
    hold(4'b1011, PATS[7], 6);
    rst = 1'b1;
    hold(4'b1111, BLK, 2);
    rst = 1'b0;
    check("rst_mid_val", int'(bus.value), 0);
    scan(PATS[9], PATS[8], PATS[7], PATS[6], 6);
    check("rst_mid_vv", vv_cnt - v0, 1);
    check("rst_mid_fe", fe_cnt - f0, 0);
    check("rst_mid_val2", int'(bus.value), 'h6789);

    v0 = vv_cnt;
    hold(4'b1110, PATS[5], 100);
    check("long_hold_vv", vv_cnt - v0, 0);
    hold(4'b1101, PATS[12], 6);
    hold(4'b1011, PATS[11], 6);
    hold(4'b0111, PATS[10], 6);
    hold(4'b1111, BLK, 3);
    check("long_hold_vv2", vv_cnt - v0, 1);
    check("long_hold_val", int'(bus.value), 'hABC5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
